// File: rtl/dnn_accel_pkg.sv
// ============================================================
// Package : dnn_accel_pkg
// Brief   : Shared CSR map, CTRL bit positions and loader state encoding.
// Rev     : 1.0
// ============================================================
`default_nettype none

package dnn_accel_pkg;

  localparam logic [1:0] CSR_SRC  = 2'd0;
  localparam logic [1:0] CSR_DST  = 2'd1;
  localparam logic [1:0] CSR_LEN  = 2'd2;
  localparam logic [1:0] CSR_CTRL = 2'd3;

  localparam int CTRL_START      = 0;
  localparam int CTRL_IRQ_EN     = 1;
  localparam int CTRL_CLEAR_DONE = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dnn_accel_sync_fifo.sv
// ============================================================
// Module : dnn_accel_sync_fifo
// Brief  : Fall-through synchronous FIFO with same-cycle push and pop.
// Rev    : 1.0
// ============================================================
`default_nettype none

module dnn_accel_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  overflow_chk: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

`default_nettype wire

// File: rtl/dnn_accel_imem_loader.sv
// ============================================================
// Module : dnn_accel_imem_loader
// Brief  : Avalon-MM read master copying a word stream into the instruction SRAM.
// Rev    : 1.0
// ============================================================
`default_nettype none

module dnn_accel_imem_loader
  import dnn_accel_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DST_AW     = 13,
  parameter int LEN_W      = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic              irq,
  output logic [31:0]       rd_address,
  output logic              rd_read,
  input  logic              rd_waitrequest,
  input  logic [31:0]       rd_readdata,
  input  logic              rd_readdatavalid,
  output logic [DST_AW-1:0] sram_address,
  output logic              sram_chipselect,
  output logic              sram_write,
  output logic [31:0]       sram_writedata,
  output logic [3:0]        sram_byteenable,
  output logic              sram_clken
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t            r_state;
  state_t            w_state_next;
  logic [31:0]       r_src;
  logic [DST_AW-1:0] r_dst;
  logic [LEN_W-1:0]  r_len;
  logic              r_irq_en;
  logic              r_done;
  logic              r_irq;
  logic [31:0]       r_readdata;
  logic [31:0]       r_rd_addr;
  logic [DST_AW-1:0] r_wr_addr;
  logic [LEN_W-1:0]  r_work_len;
  logic [LEN_W-1:0]  r_issued;
  logic [LEN_W-1:0]  r_written;
  logic [CNT_W-1:0]  r_outstanding;

  logic [CNT_W-1:0]  w_fifo_count;
  logic [31:0]       w_fifo_head;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_rvalid;
  logic              w_push;
  logic              w_pop;
  logic              w_accept;
  logic              w_busy;
  logic [CNT_W:0]    w_credit;
  logic              w_ctrl_wr;
  logic              w_start;
  logic              w_finish;
  logic              w_done_next;
  logic              w_irq_en_next;

  assign w_ctrl_wr = csr_write && (csr_address == CSR_CTRL);
  assign w_start   = w_ctrl_wr && csr_writedata[CTRL_START] && (r_state == IDLE);
  assign w_finish  = (r_state == DRAIN) && (r_written == r_work_len) && w_fifo_empty;

  always_comb begin
    w_irq_en_next = w_ctrl_wr ? csr_writedata[CTRL_IRQ_EN] : r_irq_en;
    w_done_next   = r_done;
    if (w_ctrl_wr && csr_writedata[CTRL_CLEAR_DONE]) w_done_next = 1'b0;
    // A zero-length start completes on the spot without touching either bus.
    if (w_start)  w_done_next = (r_len == '0);
    if (w_finish) w_done_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start && (r_len != '0)) w_state_next = ISSUE;
      ISSUE:   if (r_issued == r_work_len)   w_state_next = DRAIN;
      DRAIN:   if (w_finish)                 w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Credit covers both in-flight reads and buffered words, so the sum only
  // falls while a request stalls and rd_read stays asserted until accepted.
  always_comb begin
    w_busy          = (r_state != IDLE);
    w_credit        = (CNT_W+1)'(r_outstanding) + (CNT_W+1)'(w_fifo_count);
    rd_read         = (r_state == ISSUE) && (r_issued < r_work_len) &&
                      (w_credit < (CNT_W+1)'(FIFO_DEPTH));
    w_accept        = rd_read && !rd_waitrequest;
    w_rvalid        = rd_readdatavalid && w_busy;
    w_pop           = w_busy && !w_fifo_empty;
    w_push          = w_rvalid && (!w_fifo_full || w_pop);
    sram_write      = w_pop;
    sram_chipselect = w_pop;
    sram_writedata  = w_pop ? w_fifo_head : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src         <= '0;
      r_dst         <= '0;
      r_len         <= '0;
      r_irq_en      <= 1'b0;
      r_done        <= 1'b0;
      r_irq         <= 1'b0;
      r_readdata    <= '0;
      r_rd_addr     <= '0;
      r_wr_addr     <= '0;
      r_work_len    <= '0;
      r_issued      <= '0;
      r_written     <= '0;
      r_outstanding <= '0;
    end else begin
      if (csr_write && !w_busy) begin
        case (csr_address)
          CSR_SRC: r_src <= {csr_writedata[31:2], 2'b00};
          CSR_DST: r_dst <= csr_writedata[DST_AW-1:0];
          CSR_LEN: r_len <= csr_writedata[LEN_W-1:0];
          default: ;
        endcase
      end
      r_done   <= w_done_next;
      r_irq_en <= w_irq_en_next;
      r_irq    <= w_done_next & w_irq_en_next;

      if (w_start) begin
        r_rd_addr     <= r_src;
        r_wr_addr     <= r_dst;
        r_work_len    <= r_len;
        r_issued      <= '0;
        r_written     <= '0;
        r_outstanding <= '0;
      end else begin
        if (w_accept) begin
          r_rd_addr <= r_rd_addr + 32'd4;
          r_issued  <= r_issued + LEN_W'(1);
        end
        if (w_pop) begin
          r_wr_addr <= r_wr_addr + DST_AW'(1);
          r_written <= r_written + LEN_W'(1);
        end
        case ({w_accept, w_rvalid})
          2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
          2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
          default: r_outstanding <= r_outstanding;
        endcase
      end

      if (csr_read) begin
        case (csr_address)
          CSR_SRC: r_readdata <= r_src;
          CSR_DST: r_readdata <= 32'(r_dst);
          CSR_LEN: r_readdata <= 32'(r_len);
          default: r_readdata <= {29'b0, r_irq_en, r_done, w_busy};
        endcase
      end
    end
  end

  dnn_accel_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (w_push),
    .push_data (rd_readdata),
    .pop       (w_pop),
    .pop_data  (w_fifo_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  overflow_chk: assert property (@(posedge clk) disable iff (reset)
                                 !(w_rvalid && w_fifo_full && !w_pop));

  assign csr_readdata    = r_readdata;
  assign irq             = r_irq;
  assign rd_address      = r_rd_addr;
  assign sram_address    = r_wr_addr;
  assign sram_byteenable = 4'hF;
  assign sram_clken      = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_dnn_accel_imem_loader.sv
// ============================================================
// Module : tb_dnn_accel_imem_loader
// Brief  : Directed bench with a fixed-latency Avalon source model.
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_dnn_accel_imem_loader;
  import dnn_accel_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  csr_address = '0;
  logic        csr_read = 1'b0;
  logic        csr_write = 1'b0;
  logic [31:0] csr_writedata = '0;
  logic [31:0] csr_readdata;
  logic        irq;
  logic [31:0] rd_address;
  logic        rd_read;
  logic        rd_waitrequest = 1'b0;
  logic [31:0] rd_readdata = '0;
  logic        rd_readdatavalid = 1'b0;
  logic [12:0] sram_address;
  logic        sram_chipselect;
  logic        sram_write;
  logic [31:0] sram_writedata;
  logic [3:0]  sram_byteenable;
  logic        sram_clken;

  dnn_accel_imem_loader dut (
    .clk              (clk),
    .reset            (reset),
    .csr_address      (csr_address),
    .csr_read         (csr_read),
    .csr_write        (csr_write),
    .csr_writedata    (csr_writedata),
    .csr_readdata     (csr_readdata),
    .irq              (irq),
    .rd_address       (rd_address),
    .rd_read          (rd_read),
    .rd_waitrequest   (rd_waitrequest),
    .rd_readdata      (rd_readdata),
    .rd_readdatavalid (rd_readdatavalid),
    .sram_address     (sram_address),
    .sram_chipselect  (sram_chipselect),
    .sram_write       (sram_write),
    .sram_writedata   (sram_writedata),
    .sram_byteenable  (sram_byteenable),
    .sram_clken       (sram_clken)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          lat = 2;
  bit          rand_wait = 1'b0;
  logic [63:0] wq[$];
  logic [31:0] aq[$];
  int          rq_due[$];
  logic [31:0] rq_addr[$];
  int          first_rdv = -1;
  int          first_wr = -1;
  int          n_acc = 0;
  int          n_wr = 0;
  int          n_rdread = 0;
  int          max_inflight = 0;
  int          hold_viol = 0;
  bit          prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] src_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Source model and bus monitor; everything happens on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (n_acc - n_wr > max_inflight) max_inflight = n_acc - n_wr;
    if (prev_wait && (!rd_read || rd_address != prev_addr)) hold_viol++;
    if (sram_write) begin
      wq.push_back({32'(sram_address), sram_writedata});
      n_wr++;
      if (first_wr < 0) first_wr = cyc;
    end
    if (rd_read) n_rdread++;
    rd_waitrequest   = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
    prev_wait        = rd_read && rd_waitrequest;
    prev_addr        = rd_address;
    rd_readdatavalid = 1'b0;
    rd_readdata      = '0;
    if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
      rd_readdatavalid = 1'b1;
      rd_readdata      = src_word(rq_addr[0]);
      void'(rq_due.pop_front());
      void'(rq_addr.pop_front());
      if (first_rdv < 0) first_rdv = cyc;
    end
    if (rd_read && !rd_waitrequest) begin
      aq.push_back(rd_address);
      rq_due.push_back(cyc + lat);
      rq_addr.push_back(rd_address);
      n_acc++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    @(negedge clk);
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    csr_address = a; csr_read = 1'b1;
    @(negedge clk);
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    bit          idle_seen = 1'b0;
    for (int k = 0; k < 300 && !idle_seen; k++) begin
      csr_rd(CSR_CTRL, s);
      idle_seen = !s[0];
    end
    check({tag, " finished"}, 64'(idle_seen), 64'd1);
  endtask

  task automatic clear_logs();
    wq.delete(); aq.delete();
    first_rdv = -1; first_wr = -1;
  endtask

  task automatic check_xfer(input string tag, input logic [31:0] src, input int dst, input int len);
    check({tag, " write count"}, 64'(wq.size()), 64'(len));
    check({tag, " read count"}, 64'(aq.size()), 64'(len));
    for (int i = 0; i < len && i < wq.size(); i++)
      check({tag, " sram word"}, wq[i], {32'((dst + i) % 8192), src_word(src + 32'(4 * i))});
    for (int i = 0; i < len && i < aq.size(); i++)
      check({tag, " rd addr"}, 64'(aq[i]), 64'(src + 32'(4 * i)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " strobes"}, 64'({rd_read, sram_write, sram_chipselect, irq, sram_byteenable, sram_clken}),
          64'({1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1}));
    check({tag, " addresses"}, {rd_address, 32'(sram_address)}, 64'd0);
    check({tag, " data"}, {sram_writedata, csr_readdata}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s;
    int          base_rd;
    bit          hit;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Basic 4-word copy, 2-cycle source latency, irq enabled.
    lat = 2;
    csr_wr(CSR_SRC, 32'h0000_1000);
    csr_wr(CSR_DST, 32'd0);
    csr_wr(CSR_LEN, 32'd4);
    clear_logs();
    csr_wr(CSR_CTRL, 32'b011);
    wait_idle("t1");
    check_xfer("t1", 32'h0000_1000, 0, 4);
    check("t1 first write latency", 64'(first_wr - first_rdv), 64'd1);
    csr_rd(CSR_CTRL, s);
    check("t1 status", 64'(s), 64'b110);
    check("t1 irq", 64'(irq), 64'd1);

    // Zero-length start: done immediately, no bus activity.
    csr_wr(CSR_LEN, 32'd0);
    clear_logs();
    base_rd = n_rdread;
    csr_wr(CSR_CTRL, 32'b001);
    csr_rd(CSR_CTRL, s);
    check("t2 status", 64'(s), 64'b010);
    repeat (5) @(negedge clk);
    check("t2 rd_read cycles", 64'(n_rdread - base_rd), 64'd0);
    check("t2 sram writes", 64'(wq.size()), 64'd0);
    check("t2 irq", 64'(irq), 64'd0);

    // Destination wraps from 8191 to 0.
    csr_wr(CSR_SRC, 32'h0000_2000);
    csr_wr(CSR_DST, 32'd8190);
    csr_wr(CSR_LEN, 32'd4);
    clear_logs();
    csr_wr(CSR_CTRL, 32'b001);
    wait_idle("t3");
    check_xfer("t3", 32'h0000_2000, 8190, 4);
    check("t3 wrap addr", 64'(wq[2][63:32]), 64'd0);

    // Random stalls with 8-cycle latency: credit limit and address hold.
    lat = 8;
    rand_wait = 1'b1;
    max_inflight = 0;
    hold_viol = 0;
    csr_wr(CSR_SRC, 32'h0000_4000);
    csr_wr(CSR_DST, 32'd100);
    csr_wr(CSR_LEN, 32'd16);
    clear_logs();
    csr_wr(CSR_CTRL, 32'b001);
    wait_idle("t4");
    rand_wait = 1'b0;
    check_xfer("t4", 32'h0000_4000, 100, 16);
    check("t4 inflight within 4", 64'(max_inflight <= 4), 64'd1);
    check("t4 address hold", 64'(hold_viol), 64'd0);

    // Reset after 3 of 10 words; late returns must be dropped.
    csr_wr(CSR_SRC, 32'h0000_8000);
    csr_wr(CSR_DST, 32'd0);
    csr_wr(CSR_LEN, 32'd10);
    clear_logs();
    csr_wr(CSR_CTRL, 32'b001);
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      #1;
      hit = (wq.size() >= 3);
    end
    check("t5 three writes seen", 64'(hit), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("t5 in reset");
    reset = 1'b0;
    base_rd = n_rdread;
    repeat (30) @(negedge clk);
    check("t5 writes after reset", 64'(wq.size()), 64'd3);
    check("t5 third word", wq[2], {32'd2, src_word(32'h0000_8008)});
    check("t5 rd_read after reset", 64'(n_rdread - base_rd), 64'd0);
    check_reset_outputs("t5 after reset");
    csr_rd(CSR_CTRL, s);
    check("t5 status", 64'(s), 64'd0);

    // SRC write while busy is ignored; clear_done drops done and irq together.
    lat = 2;
    csr_wr(CSR_SRC, 32'h0000_3000);
    csr_wr(CSR_DST, 32'd0);
    csr_wr(CSR_LEN, 32'd8);
    clear_logs();
    csr_wr(CSR_CTRL, 32'b011);
    csr_wr(CSR_SRC, 32'hDEAD_0000);
    wait_idle("t6");
    csr_rd(CSR_SRC, s);
    check("t6 src unchanged", 64'(s), 64'h0000_3000);
    check("t6 irq set", 64'(irq), 64'd1);
    csr_wr(CSR_CTRL, 32'b110);
    check("t6 irq cleared", 64'(irq), 64'd0);
    csr_rd(CSR_CTRL, s);
    check("t6 status", 64'(s), 64'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
